// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the bus master and its slave partner.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RNACK,
    ST_STOP
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit timing: CLK_DIV clocks per phase, four phases per SCL bit.
// Held at phase 0 while not running so every transfer starts on a clean bit boundary.
module i2c_phase_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  output logic [1:0] o_phase,
  output logic       o_sample,
  output logic       o_bit_end
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [1:0]    r_phase;
  logic          w_tick;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_phase <= '0;
    end else if (!i_run) begin
      r_div   <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_div   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign o_phase   = r_phase;
  // The edge leaving P2 is the sampling point (entry to P3).
  assign o_sample  = w_tick && (r_phase == 2'd2);
  assign o_bit_end = w_tick && (r_phase == 2'd3);

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, {addr,rw}, ACK check, one data byte, STOP.
// Bus lines are open-drain (0 or Z) and decoded from FSM state and bit phase.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  inout  wire        i2c_sda,
  output logic       i2c_scl
);

  i2c_state_t r_state, w_next;
  logic [7:0] r_shift, r_wdata, r_data_out;
  logic [2:0] r_bit_cnt;
  logic       r_rw, r_ack, r_ready;
  logic [1:0] w_phase;
  logic       w_sample, w_bit_end, w_run, w_accept, w_last_bit;
  logic       w_sda_low, w_scl_low, w_sda_in;

  assign w_run      = (r_state != ST_IDLE);
  assign w_accept   = (r_state == ST_IDLE) && enable;
  assign w_last_bit = (r_bit_cnt == 3'd7);
  assign w_sda_in   = i2c_sda;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .i_run     (w_run),
    .o_phase   (w_phase),
    .o_sample  (w_sample),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_sda_low = 1'b0;
    w_scl_low = 1'b0;
    case (r_state)
      ST_IDLE:  if (enable) w_next = ST_START;
      ST_START: begin
        w_sda_low = w_phase[1];
        if (w_bit_end) w_next = ST_ADDR;
      end
      ST_ADDR, ST_WDATA: begin
        w_scl_low = !w_phase[1];
        w_sda_low = !r_shift[7];
        if (w_bit_end && w_last_bit) w_next = (r_state == ST_ADDR) ? ST_ADDR_ACK : ST_WACK;
      end
      ST_ADDR_ACK: begin
        w_scl_low = !w_phase[1];
        if (w_bit_end) w_next = (r_ack != ACK) ? ST_STOP : (r_rw ? ST_RDATA : ST_WDATA);
      end
      ST_WACK: begin
        w_scl_low = !w_phase[1];
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_RDATA: begin
        w_scl_low = !w_phase[1];
        if (w_bit_end && w_last_bit) w_next = ST_RNACK;
      end
      ST_RNACK: begin
        w_scl_low = !w_phase[1];
        w_sda_low = ~NACK;
        if (w_bit_end) w_next = ST_STOP;
      end
      ST_STOP: begin
        // SDA held low until SCL has been high for a phase, then released.
        w_scl_low = !w_phase[1];
        w_sda_low = (w_phase != 2'd3);
        if (w_bit_end) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift    <= '0;
      r_wdata    <= '0;
      r_bit_cnt  <= '0;
      r_rw       <= 1'b0;
      r_ack      <= NACK;
      r_data_out <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_shift   <= {addr, rw};
        r_wdata   <= data_in;
        r_rw      <= rw;
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_ack <= w_sda_in;
        if (r_state == ST_RDATA) begin
          r_shift <= {r_shift[6:0], w_sda_in};
          if (w_last_bit) r_data_out <= {r_shift[6:0], w_sda_in};
        end
      end else if (w_bit_end) begin
        case (r_state)
          ST_ADDR, ST_WDATA: begin
            r_shift   <= {r_shift[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          ST_RDATA:    r_bit_cnt <= r_bit_cnt + 3'd1;
          ST_ADDR_ACK: r_shift   <= r_wdata;
          default:     ;
        endcase
      end
    end
  end

  assign i2c_sda  = w_sda_low ? 1'b0 : 1'bz;
  assign i2c_scl  = w_scl_low ? 1'b0 : 1'bz;
  assign data_out = r_data_out;
  assign ready    = r_ready;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: behavioural slave at 7'h2A, bus decoder and scoreboard.
module tb_i2c_master_controller;

  localparam int         DIV = 2;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_in = '0;
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] data_out;
  logic       ready;
  wire        sda_bus;
  wire        scl_bus;

  pullup (sda_bus);
  pullup (scl_bus);

  always #5 clk = ~clk;

  logic s_drive_low = 1'b0;
  assign sda_bus = s_drive_low ? 1'b0 : 1'bz;

  i2c_master_controller #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .enable   (enable),
    .rw       (rw),
    .data_out (data_out),
    .ready    (ready),
    .i2c_sda  (sda_bus),
    .i2c_scl  (scl_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural slave: modes 1 addr byte, 2 addr ack, 3 write byte, 4 write ack, 5 read byte, 6 master ack.
  logic       s_prev_scl = 1'b1, s_prev_sda = 1'b1, s_scl, s_sda, s_rw = 1'b0;
  int         s_mode = 0, s_cnt = 0;
  logic [7:0] s_rx = '0, s_tx = '0, s_mem = '0, s_tx_byte = '0;

  always @(negedge clk) begin
    s_scl = scl_bus;
    s_sda = sda_bus;
    if (s_prev_scl && s_scl && s_prev_sda && !s_sda) begin
      s_mode = 1; s_cnt = 0; s_drive_low = 1'b0;
    end else if (s_prev_scl && s_scl && !s_prev_sda && s_sda) begin
      s_mode = 0; s_drive_low = 1'b0;
    end else if (!s_prev_scl && s_scl) begin
      if (s_mode == 1 || s_mode == 3) begin
        s_rx = {s_rx[6:0], s_sda};
        s_cnt++;
      end
    end else if (s_prev_scl && !s_scl) begin
      case (s_mode)
        1: if (s_cnt == 8) begin
             if (s_rx[7:1] == SLV) begin
               s_rw = s_rx[0]; s_drive_low = 1'b1; s_mode = 2;
             end else s_mode = 0;
           end
        2: begin
             s_drive_low = 1'b0;
             if (s_rw) begin
               s_tx = s_tx_byte; s_drive_low = !s_tx[7]; s_cnt = 1; s_mode = 5;
             end else begin
               s_cnt = 0; s_mode = 3;
             end
           end
        3: if (s_cnt == 8) begin s_mem = s_rx; s_drive_low = 1'b1; s_mode = 4; end
        4: begin s_drive_low = 1'b0; s_mode = 0; end
        5: if (s_cnt == 8) begin
             s_drive_low = 1'b0; s_mode = 6;
           end else begin
             s_drive_low = !s_tx[7 - s_cnt]; s_cnt++;
           end
        default: ;
      endcase
    end
    s_prev_scl = s_scl;
    s_prev_sda = s_sda;
  end

  typedef struct {
    logic [31:0] bits;
    int          nbits;
    logic [7:0]  dout;
    int          cycles;
    bit          chk_mem;
    logic [7:0]  mem;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: decodes START/bits/STOP from the bus and scores each transfer when ready returns.
  logic        m_prev_scl = 1'b1, m_prev_sda = 1'b1, m_prev_ready = 1'b0, m_scl, m_sda;
  bit          m_active = 1'b0;
  int          m_nbits = 0, m_starts = 0, m_stops = 0, m_low = 0;
  logic [31:0] m_bits = '0;
  exp_t        m_e;

  always @(negedge clk) begin
    m_scl = scl_bus;
    m_sda = sda_bus;
    if (!rst) begin
      m_active = 1'b0; m_nbits = 0; m_bits = '0; m_starts = 0; m_stops = 0;
    end else begin
      if (m_prev_scl && m_scl && m_prev_sda && !m_sda) begin
        m_starts++; m_nbits = 0; m_bits = '0;
      end else if (m_prev_scl && m_scl && !m_prev_sda && m_sda) begin
        // the SCL pulse that carries STOP is not a data bit
        m_stops++; m_bits = m_bits >> 1; m_nbits--;
      end else if (!m_prev_scl && m_scl) begin
        m_bits = {m_bits[30:0], m_sda}; m_nbits++;
      end
      if (m_prev_ready && !ready) begin
        m_active = 1'b1; m_low = 0; m_starts = 0; m_stops = 0;
      end
      if (!ready) m_low++;
      if (!m_prev_ready && ready && m_active) begin
        m_active = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_txn: got transfer expected none");
        end else begin
          m_e = exp_q.pop_front();
          check("frame_bits", m_bits, m_e.bits);
          check("frame_nbits", m_nbits, m_e.nbits);
          check("start_count", m_starts, 1);
          check("stop_count", m_stops, 1);
          check("data_out", {24'b0, data_out}, {24'b0, m_e.dout});
          check("busy_cycles", m_low, m_e.cycles);
          if (m_e.chk_mem) check("slave_mem", {24'b0, s_mem}, {24'b0, m_e.mem});
        end
      end
    end
    m_prev_scl   = m_scl;
    m_prev_sda   = m_sda;
    m_prev_ready = ready;
  end

  logic [7:0] model_dout = '0;

  task automatic wait_ready();
    int t = 0;
    while (ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got %b expected 1", ready);
    end
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d,
                       input logic [7:0] sd, input bit push, input bit poke);
    exp_t e;
    bit   present;
    wait_ready();
    present   = (a == SLV);
    s_tx_byte = sd;
    if (present) begin
      e.nbits = 18;
      e.bits  = {14'b0, a, r, 1'b0, (r ? sd : d), (r ? 1'b1 : 1'b0)};
      if (r && push) model_dout = sd;
    end else begin
      e.nbits = 9;
      e.bits  = {23'b0, a, r, 1'b1};
    end
    e.dout    = model_dout;
    e.cycles  = 4 * DIV * (e.nbits + 2);
    e.chk_mem = present && !r;
    e.mem     = d;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    addr = a; rw = r; data_in = d; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; addr = 7'($urandom); rw = 1'($urandom); data_in = 8'($urandom);
    if (poke) begin
      repeat (20 * DIV) @(negedge clk);
      addr = SLV; rw = ~r; data_in = ~d; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
    end
  endtask

  logic [6:0] ra;
  logic [7:0] rd, rs;
  logic       rr;
  int         tq;

  initial begin
    #15;
    check("reset_ready", {31'b0, ready}, 32'd0);
    check("reset_sda", {31'b0, sda_bus}, 32'd1);
    check("reset_scl", {31'b0, scl_bus}, 32'd1);
    check("reset_data_out", {24'b0, data_out}, 32'd0);
    #5 rst = 1'b1;
    #1 check("ready_before_edge", {31'b0, ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_after_release", {31'b0, ready}, 32'd1);

    issue(SLV, 1'b0, 8'hAA, 8'h00, 1'b1, 1'b0);
    issue(SLV, 1'b1, 8'h13, 8'h5C, 1'b1, 1'b0);
    issue(7'h55, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0);
    issue(7'h55, 1'b1, 8'h77, 8'hC3, 1'b1, 1'b0);
    issue(SLV, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1);
    issue(SLV, 1'b1, 8'h00, 8'hA5, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV;
      rr = 1'($urandom);
      rd = 8'($urandom);
      rs = 8'($urandom);
      issue(ra, rr, rd, rs, 1'b1, 1'b0);
    end

    // Abort a write partway through its data byte.
    issue(SLV, 1'b0, 8'hE7, 8'h00, 1'b0, 1'b0);
    repeat (4 * DIV * 12) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_sda", {31'b0, sda_bus}, 32'd1);
    check("abort_scl", {31'b0, scl_bus}, 32'd1);
    check("abort_ready", {31'b0, ready}, 32'd0);
    check("abort_data_out", {24'b0, data_out}, 32'd0);
    model_dout = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(SLV, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0);
    issue(SLV, 1'b1, 8'h00, 8'h3E, 1'b1, 1'b0);

    tq = 0;
    while (exp_q.size() != 0 && tq < 5000) begin
      @(negedge clk);
      tq++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
